trigger_manager: RTL and testbench

//  Multi-source trigger front end and event bookkeeper between the trigger inputs and the DRS control block.

---
 rtl/trigger_manager_pkg.sv | 22 ++
 rtl/trigger_manager_if.sv | 37 +++
 rtl/trigger_manager_sync_fifo_fwft.sv | 71 +++++++
 rtl/trigger_manager.sv | 153 +++++++++++++++
 tb/tb_trigger_manager.sv | 341 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/trigger_manager_pkg.sv
// Shared definitions for the trigger manager and its readout consumers.
//   DEF_*      default parameter values for the trigger manager
//   EVT_REC_W  width of one packed event record {event number, timestamp, pattern}
//   trig_state_e  accept/holdoff FSM state encoding
package trigger_manager_pkg;

  localparam int DEF_N_TRIG     = 4;
  localparam int DEF_TS_WIDTH   = 48;
  localparam int DEF_EVT_WIDTH  = 32;
  localparam int DEF_LOST_WIDTH = 16;
  localparam int DEF_HOLD_WIDTH = 8;
  localparam int DEF_FIFO_DEPTH = 8;

  // Packed record layout, MSB first: event number, timestamp, trigger pattern.
  localparam int EVT_REC_W = DEF_EVT_WIDTH + DEF_TS_WIDTH + DEF_N_TRIG;

  typedef enum logic [0:0] {
    ST_IDLE    = 1'b0,
    ST_HOLDOFF = 1'b1
  } trig_state_e;

endpackage

// File: rtl/trigger_manager_if.sv
// Event record stream from the trigger manager to the readout.
// Handshake: the producer drives evt_valid_o and holds the record stable while
// it is high; a record is transferred on every rising clock edge where
// evt_valid_o and evt_ready_i are both 1. evt_ready_i may be high while
// evt_valid_o is low (no transfer). The producer never drops evt_valid_o
// without a transfer, except on reset or resync.
//   master: producer (trigger_manager)
//   slave : consumer (readout)
interface trigger_manager_if #(
  parameter int N_TRIG    = 4,
  parameter int TS_WIDTH  = 48,
  parameter int EVT_WIDTH = 32
);

  logic                 evt_valid_o;
  logic                 evt_ready_i;
  logic [EVT_WIDTH-1:0] evt_number_o;
  logic [TS_WIDTH-1:0]  evt_timestamp_o;
  logic [N_TRIG-1:0]    evt_pattern_o;

  modport master (
    output evt_valid_o,
    output evt_number_o,
    output evt_timestamp_o,
    output evt_pattern_o,
    input  evt_ready_i
  );

  modport slave (
    input  evt_valid_o,
    input  evt_number_o,
    input  evt_timestamp_o,
    input  evt_pattern_o,
    output evt_ready_i
  );

endinterface

// File: rtl/trigger_manager_sync_fifo_fwft.sv
// Single-clock first-word-fall-through FIFO.
//   clock, reset_n  clock and asynchronous active-low reset
//   clear           synchronous flush (empties the FIFO)
//   push, din       write request and data; ignored when full
//   pop             read request; ignored when empty
//   dout            head entry, valid whenever empty=0 (0 when empty)
//   full, empty     occupancy flags
//   count           occupancy, 0..DEPTH
// DEPTH must be a power of two and at least 2 so the pointers wrap naturally.
module sync_fifo_fwft #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     clear,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [AW-1:0] PTR_ONE = AW'(1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_MAX);
  assign empty   = (count == '0);
  assign do_push = push && !full && !clear;
  assign do_pop  = pop && !empty && !clear;

  // Gating the head with empty keeps dout at 0 after reset and flush
  // without having to reset the storage array.
  assign dout = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/trigger_manager.sv
// Multi-source trigger front end and event bookkeeper for the DRS control block.
//   clock, reset_n   clock and asynchronous active-low reset
//   resync_i         synchronous clear of timestamp, counters, FIFO and FSM
//   trig_i           trigger levels (synchronous to clock)
//   trig_mask_i      per-input enable, 1 = enabled
//   holdoff_i        dead cycles after each accepted trigger (sampled at accept)
//   busy_i           DRS busy, refuses triggers while high
//   trigger_o        one-cycle accepted-trigger pulse to the DRS
//   evt              event record stream (FWFT FIFO head), master side
//   timestamp_o      free-running timestamp
//   event_counter_o  accepted-trigger count (wraps)
//   lost_counter_o   refused-trigger count (saturates)
//   fifo_count_o     record FIFO occupancy
//   state_o          accept/holdoff FSM state
module trigger_manager
  import trigger_manager_pkg::*;
#(
  parameter int N_TRIG     = DEF_N_TRIG,
  parameter int TS_WIDTH   = DEF_TS_WIDTH,
  parameter int EVT_WIDTH  = DEF_EVT_WIDTH,
  parameter int LOST_WIDTH = DEF_LOST_WIDTH,
  parameter int HOLD_WIDTH = DEF_HOLD_WIDTH,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic                        clock,
  input  logic                        reset_n,
  input  logic                        resync_i,
  input  logic [N_TRIG-1:0]           trig_i,
  input  logic [N_TRIG-1:0]           trig_mask_i,
  input  logic [HOLD_WIDTH-1:0]       holdoff_i,
  input  logic                        busy_i,
  output logic                        trigger_o,
  trigger_manager_if.master           evt,
  output logic [TS_WIDTH-1:0]         timestamp_o,
  output logic [EVT_WIDTH-1:0]        event_counter_o,
  output logic [LOST_WIDTH-1:0]       lost_counter_o,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count_o,
  output trig_state_e                 state_o
);

  localparam int REC_W = EVT_WIDTH + TS_WIDTH + N_TRIG;
  localparam logic [TS_WIDTH-1:0]   TS_ONE   = TS_WIDTH'(1);
  localparam logic [EVT_WIDTH-1:0]  EVT_ONE  = EVT_WIDTH'(1);
  localparam logic [LOST_WIDTH-1:0] LOST_ONE = LOST_WIDTH'(1);
  localparam logic [HOLD_WIDTH-1:0] HOLD_ONE = HOLD_WIDTH'(1);

  trig_state_e           state;
  logic [HOLD_WIDTH-1:0] hold_cnt;
  logic [N_TRIG-1:0]     trig_r;
  logic [N_TRIG-1:0]     edge_v;
  logic                  any_edge;
  logic                  accept;
  logic                  lost_hit;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  fifo_pop;
  logic [REC_W-1:0]      rec_in;
  logic [REC_W-1:0]      rec_out;

  // Rising edges on enabled inputs only; a held-high input fires once.
  assign edge_v   = trig_i & ~trig_r & trig_mask_i;
  assign any_edge = |edge_v;

  // Full is evaluated before any same-cycle pop: a pop does not make room
  // for a trigger arriving in the same cycle.
  assign accept   = any_edge && (state == ST_IDLE) && !busy_i && !fifo_full && !resync_i;
  assign lost_hit = any_edge && !accept && !resync_i;

  // Record carries the pre-increment event number and the detection-cycle timestamp.
  assign rec_in   = {event_counter_o, timestamp_o, edge_v};
  assign fifo_pop = evt.evt_valid_o && evt.evt_ready_i;

  sync_fifo_fwft #(
    .WIDTH (REC_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock   (clock),
    .reset_n (reset_n),
    .clear   (resync_i),
    .push    (accept),
    .din     (rec_in),
    .pop     (fifo_pop),
    .dout    (rec_out),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count_o)
  );

  assign evt.evt_valid_o     = !fifo_empty;
  assign evt.evt_number_o    = rec_out[REC_W-1 -: EVT_WIDTH];
  assign evt.evt_timestamp_o = rec_out[N_TRIG +: TS_WIDTH];
  assign evt.evt_pattern_o   = rec_out[N_TRIG-1:0];

  assign state_o = state;

  // Timestamp, edge history and event/lost counters.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      trig_r          <= '0;
      timestamp_o     <= '0;
      event_counter_o <= '0;
      lost_counter_o  <= '0;
    end else begin
      trig_r <= trig_i;
      if (resync_i) begin
        timestamp_o     <= '0;
        event_counter_o <= '0;
        lost_counter_o  <= '0;
      end else begin
        timestamp_o <= timestamp_o + TS_ONE;
        if (accept) event_counter_o <= event_counter_o + EVT_ONE;
        if (lost_hit && (lost_counter_o != '1)) lost_counter_o <= lost_counter_o + LOST_ONE;
      end
    end
  end

  // Accept/holdoff FSM. holdoff_i is captured only at accept; a zero holdoff
  // keeps the FSM in IDLE so consecutive-cycle accepts are possible.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      hold_cnt  <= '0;
      trigger_o <= 1'b0;
    end else if (resync_i) begin
      state     <= ST_IDLE;
      hold_cnt  <= '0;
      trigger_o <= 1'b0;
    end else begin
      trigger_o <= accept;
      case (state)
        ST_IDLE: begin
          if (accept && (holdoff_i != '0)) begin
            state    <= ST_HOLDOFF;
            hold_cnt <= holdoff_i;
          end
        end
        ST_HOLDOFF: begin
          if (hold_cnt <= HOLD_ONE) begin
            state    <= ST_IDLE;
            hold_cnt <= '0;
          end else begin
            hold_cnt <= hold_cnt - HOLD_ONE;
          end
        end
        default: begin
          state    <= ST_IDLE;
          hold_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_trigger_manager.sv
module tb_trigger_manager;
  import trigger_manager_pkg::*;

  localparam int NT    = 4;
  localparam int TSW   = 48;
  localparam int EVW   = 32;
  localparam int LW    = 16;
  localparam int HW    = 8;
  localparam int DEPTH = 8;
  localparam int CW    = $clog2(DEPTH) + 1;
  localparam int RW    = EVW + TSW + NT;

  // ---------------- clock / reset ----------------
  logic           clock = 1'b0;
  logic           reset_n;
  logic           resync_i;
  logic [NT-1:0]  trig_i;
  logic [NT-1:0]  trig_mask_i;
  logic [HW-1:0]  holdoff_i;
  logic           busy_i;
  logic           trigger_o;
  logic [TSW-1:0] timestamp_o;
  logic [EVW-1:0] event_counter_o;
  logic [LW-1:0]  lost_counter_o;
  logic [CW-1:0]  fifo_count_o;
  trig_state_e    state_o;

  trigger_manager_if #(.N_TRIG(NT), .TS_WIDTH(TSW), .EVT_WIDTH(EVW)) evt_if ();

  trigger_manager #(
    .N_TRIG(NT), .TS_WIDTH(TSW), .EVT_WIDTH(EVW),
    .LOST_WIDTH(LW), .HOLD_WIDTH(HW), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clock           (clock),
    .reset_n         (reset_n),
    .resync_i        (resync_i),
    .trig_i          (trig_i),
    .trig_mask_i     (trig_mask_i),
    .holdoff_i       (holdoff_i),
    .busy_i          (busy_i),
    .trigger_o       (trigger_o),
    .evt             (evt_if),
    .timestamp_o     (timestamp_o),
    .event_counter_o (event_counter_o),
    .lost_counter_o  (lost_counter_o),
    .fifo_count_o    (fifo_count_o),
    .state_o         (state_o)
  );

  always #5 clock = ~clock;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int errors = 0;
  int checks = 0;
  int exp_ev = 0;
  logic [RW-1:0]  exp_q[$];
  logic [RW-1:0]  mon_got;
  logic [RW-1:0]  mon_exp;
  logic [RW-1:0]  head;
  logic [TSW-1:0] m_ts;

  assign head = {evt_if.evt_number_o, evt_if.evt_timestamp_o, evt_if.evt_pattern_o};

  // Reference timestamp: counts cycles since reset release or last resync.
  always @(posedge clock or negedge reset_n) begin
    if (!reset_n)      m_ts <= '0;
    else if (resync_i) m_ts <= '0;
    else               m_ts <= m_ts + TSW'(1);
  end

  // Every handshake transfer must match the oldest expected record.
  always @(negedge clock) begin
    if (reset_n && evt_if.evt_valid_o && evt_if.evt_ready_i) begin
      checks++;
      mon_got = head;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL pop_unexpected got=%h expected=none", mon_got);
      end else begin
        mon_exp = exp_q.pop_front();
        if (mon_got !== mon_exp) begin
          errors++;
          $display("FAIL pop_record got=%h expected=%h", mon_got, mon_exp);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  // Called while driving an edge that must be accepted on the next clock.
  task automatic push_exp(input logic [NT-1:0] pat);
    exp_q.push_back({EVW'(exp_ev), m_ts, pat});
    exp_ev++;
  endtask

  task automatic do_resync();
    resync_i = 1'b1;
    exp_q.delete();
    exp_ev = 0;
    cyc();
    resync_i = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset_n = 1'b0; resync_i = 1'b0; trig_i = '0; trig_mask_i = '0;
    holdoff_i = '0; busy_i = 1'b0; evt_if.evt_ready_i = 1'b1;
    cyc(); cyc();
    checks++;
    if ({trigger_o, evt_if.evt_valid_o, head, timestamp_o, event_counter_o, lost_counter_o, fifo_count_o} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got trig=%b valid=%b ts=%0d ev=%0d lost=%0d cnt=%0d expected all 0",
               trigger_o, evt_if.evt_valid_o, timestamp_o, event_counter_o, lost_counter_o, fifo_count_o);
    end
    checks++;
    if (state_o !== ST_IDLE) begin errors++; $display("FAIL reset_state got=%0d expected=%0d", state_o, ST_IDLE); end
    reset_n = 1'b1;
  endtask

  task automatic test_single();
    int guard = 0;
    trig_mask_i = 4'b0001; holdoff_i = '0;
    while (m_ts != TSW'(100) && guard < 300) begin cyc(); guard++; end
    checks++;
    if (timestamp_o !== TSW'(100)) begin errors++; $display("FAIL single_ts got=%0d expected=100", timestamp_o); end
    trig_i = 4'b0001; push_exp(4'b0001);
    cyc();
    checks++;
    if (trigger_o !== 1'b1) begin errors++; $display("FAIL single_trigger got=%b expected=1", trigger_o); end
    checks++;
    if (event_counter_o !== EVW'(1)) begin errors++; $display("FAIL single_evcnt got=%0d expected=1", event_counter_o); end
    checks++;
    if (head !== {32'd0, 48'd100, 4'b0001}) begin errors++; $display("FAIL single_head got=%h expected=%h", head, {32'd0, 48'd100, 4'b0001}); end
    cyc();  // input still held high: no second trigger
    checks++;
    if (trigger_o !== 1'b0 || event_counter_o !== EVW'(1)) begin
      errors++; $display("FAIL single_held got trig=%b ev=%0d expected trig=0 ev=1", trigger_o, event_counter_o);
    end
    trig_i = '0; cyc();
  endtask

  task automatic test_multi();
    trig_mask_i = 4'b0110;
    trig_i = 4'b0110; push_exp(4'b0110);
    cyc();
    checks++;
    if (trigger_o !== 1'b1 || evt_if.evt_pattern_o !== 4'b0110) begin
      errors++; $display("FAIL multi_accept got trig=%b pat=%b expected trig=1 pat=0110", trigger_o, evt_if.evt_pattern_o);
    end
    trig_i = '0; cyc();
    trig_i = 4'b1000; cyc();
    checks++;
    if (trigger_o !== 1'b0 || lost_counter_o !== '0 || event_counter_o !== EVW'(2)) begin
      errors++; $display("FAIL multi_masked got trig=%b lost=%0d ev=%0d expected trig=0 lost=0 ev=2",
                         trigger_o, lost_counter_o, event_counter_o);
    end
    trig_i = '0; cyc();
  endtask

  task automatic test_back_to_back();
    trig_mask_i = 4'b1111; holdoff_i = '0;
    trig_i = 4'b0001; push_exp(4'b0001); cyc();
    checks++;
    if (trigger_o !== 1'b1) begin errors++; $display("FAIL b2b_first got=%b expected=1", trigger_o); end
    trig_i = 4'b0010; push_exp(4'b0010); cyc();
    checks++;
    if (trigger_o !== 1'b1 || event_counter_o !== EVW'(4)) begin
      errors++; $display("FAIL b2b_second got trig=%b ev=%0d expected trig=1 ev=4", trigger_o, event_counter_o);
    end
    trig_i = '0; cyc();
  endtask

  task automatic test_holdoff();
    logic        exp_trig;
    trig_state_e exp_state;
    holdoff_i = HW'(5);
    for (int i = 0; i < 7; i++) begin
      trig_i = (i % 2 == 1) ? 4'b0010 : 4'b0001;
      if (i == 0 || i == 6) push_exp(trig_i);
      if (i == 3) holdoff_i = '0;  // must not shorten the running holdoff
      cyc();
      exp_trig  = (i == 0 || i == 6);
      exp_state = (i <= 4) ? ST_HOLDOFF : ST_IDLE;
      checks++;
      if (trigger_o !== exp_trig || state_o !== exp_state) begin
        errors++; $display("FAIL holdoff_step%0d got trig=%b st=%0d expected trig=%b st=%0d",
                           i, trigger_o, state_o, exp_trig, exp_state);
      end
    end
    checks++;
    if (lost_counter_o !== LW'(5) || event_counter_o !== EVW'(6)) begin
      errors++; $display("FAIL holdoff_counts got lost=%0d ev=%0d expected lost=5 ev=6", lost_counter_o, event_counter_o);
    end
    trig_i = '0; cyc();
  endtask

  task automatic test_fifo_full();
    int guard = 0;
    evt_if.evt_ready_i = 1'b0;
    do_resync();
    checks++;
    if (event_counter_o !== '0 || lost_counter_o !== '0 || fifo_count_o !== '0) begin
      errors++; $display("FAIL full_cleared got ev=%0d lost=%0d cnt=%0d expected 0 0 0", event_counter_o, lost_counter_o, fifo_count_o);
    end
    for (int k = 0; k < 10; k++) begin
      trig_i = 4'b0001;
      if (k < DEPTH) push_exp(4'b0001);
      cyc();
      trig_i = '0; cyc(); cyc();
    end
    checks++;
    if (fifo_count_o !== CW'(8) || lost_counter_o !== LW'(2) || event_counter_o !== EVW'(8)) begin
      errors++; $display("FAIL full_counts got cnt=%0d lost=%0d ev=%0d expected cnt=8 lost=2 ev=8",
                         fifo_count_o, lost_counter_o, event_counter_o);
    end
    checks++;
    if (evt_if.evt_valid_o !== 1'b1 || evt_if.evt_number_o !== EVW'(0)) begin
      errors++; $display("FAIL full_head got valid=%b num=%0d expected valid=1 num=0", evt_if.evt_valid_o, evt_if.evt_number_o);
    end
    // Pop and edge in the same cycle while full: the edge is still refused.
    evt_if.evt_ready_i = 1'b1; trig_i = 4'b0001;
    cyc();
    checks++;
    if (trigger_o !== 1'b0 || fifo_count_o !== CW'(7) || lost_counter_o !== LW'(3)) begin
      errors++; $display("FAIL full_pop_push got trig=%b cnt=%0d lost=%0d expected trig=0 cnt=7 lost=3",
                         trigger_o, fifo_count_o, lost_counter_o);
    end
    trig_i = '0;
    while (evt_if.evt_valid_o && guard < 30) begin cyc(); guard++; end
    checks++;
    if (evt_if.evt_valid_o !== 1'b0 || fifo_count_o !== '0 || exp_q.size() != 0) begin
      errors++; $display("FAIL full_drain got valid=%b cnt=%0d left=%0d expected valid=0 cnt=0 left=0",
                         evt_if.evt_valid_o, fifo_count_o, exp_q.size());
    end
    cyc();  // pop request while empty
    checks++;
    if (fifo_count_o !== '0) begin errors++; $display("FAIL empty_pop got cnt=%0d expected=0", fifo_count_o); end
  endtask

  task automatic test_lost_saturate();
    do_resync();
    busy_i = 1'b1; trig_mask_i = 4'b1111;
    for (int i = 0; i < 65534; i++) begin
      trig_i = (i % 2 == 1) ? 4'b1010 : 4'b0101;
      cyc();
    end
    checks++;
    if (lost_counter_o !== 16'hFFFE) begin errors++; $display("FAIL lost_preset got=%h expected=fffe", lost_counter_o); end
    for (int i = 0; i < 3; i++) begin
      trig_i = (i % 2 == 1) ? 4'b0101 : 4'b1010;
      cyc();
    end
    checks++;
    if (lost_counter_o !== 16'hFFFF || event_counter_o !== '0 || trigger_o !== 1'b0) begin
      errors++; $display("FAIL lost_saturate got lost=%h ev=%0d trig=%b expected lost=ffff ev=0 trig=0",
                         lost_counter_o, event_counter_o, trigger_o);
    end
    trig_i = '0; busy_i = 1'b0; cyc();
  endtask

  task automatic test_resync();
    do_resync();
    evt_if.evt_ready_i = 1'b0; holdoff_i = '0;
    for (int k = 0; k < 3; k++) begin
      trig_i = 4'b0001; push_exp(4'b0001); cyc();
      trig_i = '0; cyc();
    end
    checks++;
    if (fifo_count_o !== CW'(3)) begin errors++; $display("FAIL resync_fill got=%0d expected=3", fifo_count_o); end
    trig_i = 4'b0001;
    do_resync();
    #0;
    checks++;
    if (trigger_o !== 1'b0 || event_counter_o !== '0 || lost_counter_o !== '0 || fifo_count_o !== '0 ||
        evt_if.evt_valid_o !== 1'b0 || timestamp_o !== '0) begin
      errors++; $display("FAIL resync_clear got trig=%b ev=%0d lost=%0d cnt=%0d valid=%b ts=%0d expected all 0",
                         trigger_o, event_counter_o, lost_counter_o, fifo_count_o, evt_if.evt_valid_o, timestamp_o);
    end
    cyc();
    checks++;
    if (timestamp_o !== TSW'(1) || trigger_o !== 1'b0) begin
      errors++; $display("FAIL resync_after got ts=%0d trig=%b expected ts=1 trig=0", timestamp_o, trigger_o);
    end
    trig_i = '0; cyc();
  endtask

  task automatic test_reset_holdoff();
    evt_if.evt_ready_i = 1'b1; holdoff_i = HW'(10);
    trig_i = 4'b0001; push_exp(4'b0001); cyc();
    checks++;
    if (state_o !== ST_HOLDOFF) begin errors++; $display("FAIL rst_hold_enter got=%0d expected=%0d", state_o, ST_HOLDOFF); end
    trig_i = '0; cyc(); cyc();
    reset_n = 1'b0;
    exp_q.delete(); exp_ev = 0;
    #1;
    checks++;
    if ({trigger_o, evt_if.evt_valid_o, head, timestamp_o, event_counter_o, lost_counter_o, fifo_count_o} !== '0 ||
        state_o !== ST_IDLE) begin
      errors++; $display("FAIL rst_async got st=%0d ts=%0d ev=%0d cnt=%0d expected all 0", state_o, timestamp_o, event_counter_o, fifo_count_o);
    end
    cyc();
    reset_n = 1'b1; holdoff_i = '0;
    cyc();
    trig_i = 4'b0001; push_exp(4'b0001); cyc();
    checks++;
    if (trigger_o !== 1'b1 || evt_if.evt_number_o !== EVW'(0) || event_counter_o !== EVW'(1)) begin
      errors++; $display("FAIL rst_first_evt got trig=%b num=%0d ev=%0d expected trig=1 num=0 ev=1",
                         trigger_o, evt_if.evt_number_o, event_counter_o);
    end
    trig_i = '0; cyc(); cyc();
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_single();
    test_multi();
    test_back_to_back();
    test_holdoff();
    test_fifo_full();
    test_lost_saturate();
    test_resync();
    test_reset_holdoff();
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL final_queue got=%0d expected=0", exp_q.size()); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
